// File: rtl/led_pkg.sv
// Shared definitions for the LED effect front end: button FSM states and default timing.
package led_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;    // 20 ms
    localparam int LONG_CYCLES_DEF     = 2 * CLK_HZ;     // 2 s

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous board inputs.
// Latency: two clock edges; no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release/long-press events, switch level.
// Latency: events registered 2+DEBOUNCE_CYCLES edges after first raw sample; no backpressure.
module button_conditioner
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int TOGGLE_MODE     = 1
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic btn_raw,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic switch
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic btn_sync;

    sync_2ff u_sync (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .async_i (btn_raw),
        .sync_o  (btn_sync)
    );

    btn_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              debounced_q, debounced_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              switch_q, switch_d;
    logic              hold_step;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        hold_step   = 1'b0;

        case (state_q)
            S_LOW: begin
                if (btn_sync) begin
                    state_d  = S_WAIT_H;
                    db_cnt_d = '0;
                end
            end
            S_WAIT_H: begin
                if (!btn_sync) begin
                    state_d = S_LOW;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = S_HIGH;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                hold_step = 1'b1;
                if (!btn_sync) begin
                    state_d  = S_WAIT_L;
                    db_cnt_d = '0;
                end
            end
            S_WAIT_L: begin
                if (btn_sync) begin
                    state_d   = S_HIGH;
                    hold_step = 1'b1;
                end else if (db_cnt_q == DB_LAST) begin
                    // Leaving the hold: no long press may share the release edge.
                    state_d   = S_LOW;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d  = db_cnt_q + 1'b1;
                    hold_step = 1'b1;
                end
            end
            default: state_d = S_LOW;
        endcase

        if (hold_step && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if ((hold_cnt_d == HOLD_LAST) && !long_done_q) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end

        debounced_d = (state_d == S_HIGH) || (state_d == S_WAIT_L);

        if (TOGGLE_MODE != 0) begin
            switch_d = switch_q;
            if (long_d) begin
                switch_d = 1'b0;
            end else if (press_d) begin
                switch_d = ~switch_q;
            end
        end else begin
            switch_d = debounced_d;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOW;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            debounced_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            switch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            debounced_q <= debounced_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            switch_q    <= switch_d;
        end
    end

    assign debounced     = debounced_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign switch        = switch_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: toggle and mirror instances driven in parallel against a run-length model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 16;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_raw = 1'b0;

    logic deb_t, press_t, rel_t, long_t, sw_t;
    logic deb_m, press_m, rel_m, long_m, sw_m;

    always #10 clk_50M = ~clk_50M;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .TOGGLE_MODE(1)) u_tog (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .debounced     (deb_t),
        .press_pulse   (press_t),
        .release_pulse (rel_t),
        .long_press    (long_t),
        .switch        (sw_t)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .TOGGLE_MODE(0)) u_mir (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .debounced     (deb_m),
        .press_pulse   (press_m),
        .release_pulse (rel_m),
        .long_press    (long_m),
        .switch        (sw_m)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: the pin is seen two samples late; the level flips after D+1
    // consecutive observations that disagree with it; long press is L-1 edges after press.
    bit m_p1, m_p2;
    bit m_deb, m_press, m_rel, m_long, m_sw, m_long_done;
    int m_run, m_hold;

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_deb = 0; m_press = 0; m_rel = 0; m_long = 0;
        m_sw = 0; m_long_done = 0; m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge();
        bit s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_p2;
        m_p2 = m_p1;
        m_p1 = btn_raw;
        m_press = 0; m_rel = 0; m_long = 0;
        m_run = (s != m_deb) ? m_run + 1 : 0;
        if (m_run == D + 1) begin
            m_deb = s;
            m_run = 0;
            if (s) begin
                m_press = 1; m_hold = 0; m_long_done = 0; m_sw = ~m_sw;
            end else begin
                m_rel = 1;
            end
        end else if (m_deb) begin
            if (m_hold < L - 1) m_hold++;
            if (m_hold == L - 1 && !m_long_done) begin
                m_long = 1; m_long_done = 1; m_sw = 0;
            end
        end
    endtask

    int edge_no = 0;
    int last_press_edge = -1000, last_rel_edge = -1000, last_long_edge = -1000;
    int n_press = 0, n_rel = 0, n_long = 0;

    task automatic step();
        @(posedge clk_50M);
        edge_no++;
        model_edge();
        #1;
        chk("tog_outputs", {deb_t, press_t, rel_t, long_t, sw_t}, {m_deb, m_press, m_rel, m_long, m_sw});
        chk("mir_outputs", {deb_m, press_m, rel_m, long_m, sw_m}, {m_deb, m_press, m_rel, m_long, m_deb});
        if (press_t) begin n_press++; last_press_edge = edge_no; end
        if (rel_t)   begin n_rel++;   last_rel_edge   = edge_no; end
        if (long_t)  begin n_long++;  last_long_edge  = edge_no; end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic lvl);
        rst_n = 1'b0;
        btn_raw = lvl;
        model_reset();
        steps(2);
        rst_n = 1'b1;
    endtask

    task automatic async_reset_check(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_tog"}, {deb_t, press_t, rel_t, long_t, sw_t}, 5'd0);
        chk({tag, "_mir"}, {deb_m, press_m, rel_m, long_m, sw_m}, 5'd0);
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int k, p0, r0, l0;
        logic lvl;

        // Reset with the button held: nothing until reset lifts, then press 6 edges later.
        rst_n = 1'b0;
        btn_raw = 1'b1;
        model_reset();
        steps(3);
        rst_n = 1'b1;
        k = edge_no + 1;
        steps(8);
        chk("press_latency", last_press_edge - k, 6);
        chk("switch_on_after_press", sw_t, 1);

        // Bounce rejection.
        do_reset(1'b0);
        p0 = n_press; r0 = n_rel;
        for (int r = 0; r < 5; r++) begin
            btn_raw = 1'b1; steps(2);
            btn_raw = 1'b0; steps(1);
        end
        steps(10);
        chk("bounce_presses", n_press - p0, 0);
        chk("bounce_releases", n_rel - r0, 0);
        chk("bounce_switch", sw_t, 0);

        // Two clean presses toggle the switch on then off.
        do_reset(1'b0);
        p0 = n_press; r0 = n_rel;
        for (int r = 0; r < 2; r++) begin
            btn_raw = 1'b1; steps(8);
            chk("toggle_switch_after_press", sw_t, (r == 0) ? 1 : 0);
            btn_raw = 1'b0;
            k = edge_no + 1;
            steps(8);
            chk("release_latency", last_rel_edge - k, 6);
        end
        chk("toggle_presses", n_press - p0, 2);
        chk("toggle_releases", n_rel - r0, 2);

        // Long press.
        do_reset(1'b0);
        p0 = n_press; r0 = n_rel; l0 = n_long;
        btn_raw = 1'b1; steps(40);
        chk("long_presses", n_press - p0, 1);
        chk("long_count", n_long - l0, 1);
        chk("long_gap", last_long_edge - last_press_edge, 15);
        chk("long_forces_switch_off", sw_t, 0);
        btn_raw = 1'b0; steps(10);
        chk("long_release", n_rel - r0, 1);

        // Short low glitch during the hold.
        do_reset(1'b0);
        r0 = n_rel; l0 = n_long;
        btn_raw = 1'b1; steps(12);
        btn_raw = 1'b0; steps(2);
        btn_raw = 1'b1; steps(20);
        chk("glitch_no_release", n_rel - r0, 0);
        chk("glitch_long_count", n_long - l0, 1);
        chk("glitch_long_gap", last_long_edge - last_press_edge, 15);
        btn_raw = 1'b0; steps(10);

        // Mirror mode follows the level; async reset mid-press clears both at once.
        do_reset(1'b0);
        btn_raw = 1'b1; steps(10);
        chk("mirror_switch_high", sw_m, 1);
        async_reset_check("arst_mid_press");
        btn_raw = 1'b0; steps(4);

        // Random runs, mostly short, some long enough to reach a long press.
        lvl = 1'b0;
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            lvl = ~lvl;
            btn_raw = lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 8);
            steps(len);
            if ($urandom_range(0, 40) == 0) async_reset_check("arst_random");
        end
        btn_raw = 1'b0;
        steps(12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
